// File: rtl/fpu_pkg.sv
// fpu_pkg: opcodes, FSM states, flag indices and canonical-NaN helper shared by the FPU files.
package fpu_pkg;
    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_EXEC,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_e;

    localparam int FL_INV = 3;
    localparam int FL_OVF = 2;
    localparam int FL_UNF = 1;
    localparam int FL_INX = 0;

    localparam int NAN_MAX_W = 128;

    function automatic logic [NAN_MAX_W-1:0] canon_nan(input int w);
        return {NAN_MAX_W{1'b1}} >> (NAN_MAX_W - w);
    endfunction
endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: combinational leading-zero counter; returns W for an all-zero input.
module fpu_lzc #(
    parameter int W = 8,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++)
            if (value[i]) count = CW'(W - 1 - i);
    end
endmodule

// File: rtl/fpu_addmul.sv
// fpu_addmul: multi-cycle parametrised add/sub/mul with round-to-nearest-even and per-result flags.
module fpu_addmul
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W = 1 + EXP_W + MAN_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   operation,
    input  logic [W-1:0] data_a,
    input  logic [W-1:0] data_b,
    input  logic         input_rdy,
    output logic         input_ack,
    output logic         output_rdy,
    input  logic         output_ack,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);
    localparam int M = MAN_W;
    localparam int E = EXP_W;
    // datapath: carry | hidden | mantissa | guard | round | sticky
    localparam int PW = M + 5;
    localparam int PRW = 2 * (M + 1);
    localparam int LW = $clog2(PW);
    localparam int XW = (E > LW ? E : LW) + 2;
    localparam int CNTW = $clog2(M + 1) + 1;
    localparam logic [W-1:0] NAN = W'(canon_nan(W));
    localparam logic signed [XW-1:0] BIAS = XW'((1 << (E - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << E) - 1);

    state_e state, state_nx;
    logic [3:0] op_q;
    logic [W-1:0] a_q, b_q;
    logic [PW-1:0] xa, xb, path;
    logic [M:0] mcand;
    logic [PRW-1:0] prod;
    logic [CNTW-1:0] cnt;
    logic signed [XW-1:0] exp_q;
    logic sign_q, zsign_q, sub_q, zero_q, special_q;

    logic sa, sb, sbe, is_add, is_mul, illegal, swap, special, invalid;
    logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [E-1:0] ea, eb, ebig, d;
    logic [M-1:0] ma, mb;
    logic [M:0] fa, fb;
    logic [PW-1:0] pbig, psml, pshf;
    logic [W-1:0] sp_res;

    assign {sa, ea, ma} = a_q;
    assign {sb, eb, mb} = b_q;

    always_comb begin
        is_mul = op_q == OP_MUL;
        is_add = op_q == OP_ADD || op_q == OP_SUB;
        illegal = !is_add && !is_mul;
        sbe = sb ^ (op_q == OP_SUB);
        zero_a = ea == '0;
        zero_b = eb == '0;
        inf_a = &ea && ma == '0;
        inf_b = &eb && mb == '0;
        nan_a = &ea && |ma;
        nan_b = &eb && |mb;
        fa = zero_a ? '0 : {1'b1, ma};
        fb = zero_b ? '0 : {1'b1, mb};
        invalid = illegal || nan_a || nan_b || (is_add && inf_a && inf_b && (sa ^ sbe))
                  || (is_mul && ((inf_a && zero_b) || (zero_a && inf_b)));
        special = invalid || inf_a || inf_b;
        sp_res = invalid ? NAN : {is_mul ? sa ^ sb : (inf_a ? sa : sbe), {E{1'b1}}, {M{1'b0}}};
        swap = {ea, fa} < {eb, fb};
        ebig = swap ? eb : ea;
        d = swap ? eb - ea : ea - eb;
        pbig = {1'b0, swap ? fb : fa, 3'b000};
        psml = {1'b0, swap ? fa : fb, 3'b000};
        pshf = psml >> d;
        pshf[0] = pshf[0] | |(psml & ((PW'(1) << d) - PW'(1)));
    end

    // one shift-add step: conditionally add the multiplicand into the top half, then shift right
    logic [M+1:0] mac;
    logic [PRW-1:0] prod_nx;
    logic [PRW+1:0] pext;
    logic [PW-1:0] mpath;

    always_comb begin
        mac = {1'b0, prod[PRW-1:M+1]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_nx = {mac, prod[M:1]};
        pext = {prod_nx, 2'b00};
        mpath = {pext[2*M+3:M], |pext[M-1:0]};
    end

    logic [LW-1:0] lz;

    fpu_lzc #(.W(PW - 1)) u_lzc (
        .value(path[PW-2:0]),
        .count(lz)
    );

    logic g, r, s, up, inx, ovf, unf;
    logic [M+1:0] mr;
    logic [M-1:0] man_r;
    logic signed [XW-1:0] er;
    logic [W-1:0] rnd_res;
    logic [3:0] rnd_fl;

    always_comb begin
        {g, r, s} = path[2:0];
        up = g & (r | s | path[3]);
        inx = g | r | s;
        mr = {1'b0, path[PW-2:3]} + {{(M+1){1'b0}}, up};
        man_r = mr[M+1] ? mr[M:1] : mr[M-1:0];
        er = exp_q + XW'(mr[M+1]);
        ovf = !zero_q && er >= EMAX;
        unf = !zero_q && !ovf && (er[XW-1] || er == '0);
        rnd_res = (zero_q || unf) ? {sign_q, {(W-1){1'b0}}}
                : ovf ? {sign_q, {E{1'b1}}, {M{1'b0}}}
                : {sign_q, er[E-1:0], man_r};
        rnd_fl = '0;
        rnd_fl[FL_OVF] = ovf;
        rnd_fl[FL_UNF] = unf;
        rnd_fl[FL_INX] = !zero_q && (ovf || unf || inx);
    end

    always_ff @(posedge clock)
        state <= reset ? S_IDLE : state_nx;

    // resolved specials spend one pass-through cycle in ROUND before DONE
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = input_rdy ? S_UNPACK : S_IDLE;
            S_UNPACK: state_nx = special ? S_ROUND : S_EXEC;
            S_EXEC:   state_nx = (!is_mul || cnt == CNTW'(M)) ? S_NORM : S_EXEC;
            S_NORM:   state_nx = S_ROUND;
            S_ROUND:  state_nx = S_DONE;
            S_DONE:   state_nx = output_ack ? S_IDLE : S_DONE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            input_ack <= 1'b0;
            output_rdy <= 1'b0;
            result <= '0;
            flags <= '0;
            cnt <= '0;
        end else begin
            input_ack <= state == S_IDLE && input_rdy;
            output_rdy <= state_nx == S_DONE;
            case (state)
                S_IDLE: if (input_rdy) begin
                    op_q <= operation;
                    a_q <= data_a;
                    b_q <= data_b;
                end
                S_UNPACK: begin
                    special_q <= special;
                    zero_q <= 1'b0;
                    cnt <= '0;
                    if (special) begin
                        result <= sp_res;
                        flags <= 4'(invalid) << FL_INV;
                    end
                    sign_q <= is_mul ? sa ^ sb : (swap ? sbe : sa);
                    zsign_q <= is_mul ? sa ^ sb : sa & sbe;
                    sub_q <= sa ^ sbe;
                    exp_q <= is_mul ? XW'(ea) + XW'(eb) - BIAS : XW'(ebig);
                    xa <= pbig;
                    xb <= pshf;
                    mcand <= fa;
                    prod <= {{(M+1){1'b0}}, fb};
                end
                S_EXEC: if (is_mul) begin
                    prod <= prod_nx;
                    cnt <= cnt == CNTW'(M) ? '0 : cnt + CNTW'(1);
                    if (cnt == CNTW'(M)) path <= mpath;
                end else begin
                    path <= sub_q ? xa - xb : xa + xb;
                end
                S_NORM: if (path == '0) begin
                    zero_q <= 1'b1;
                    sign_q <= zsign_q;
                end else if (path[PW-1]) begin
                    path <= {1'b0, path[PW-1:2], path[1] | path[0]};
                    exp_q <= exp_q + XW'(1);
                end else begin
                    path <= path << lz;
                    exp_q <= exp_q - XW'(lz);
                end
                S_ROUND: if (!special_q) begin
                    result <= rnd_res;
                    flags <= rnd_fl;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_addmul.sv
// tb_fpu_addmul: scoreboard bench for fpu_addmul at single precision (EXP_W=8, MAN_W=23).
module tb_fpu_addmul;
    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] MUL = 4'b0010;
    localparam logic [3:0] BAD = 4'b0111;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [3:0] operation = '0;
    logic [31:0] data_a = '0;
    logic [31:0] data_b = '0;
    logic input_rdy = 1'b0;
    logic output_ack = 1'b0;
    logic input_ack, output_rdy;
    logic [31:0] result;
    logic [3:0] flags;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    fpu_addmul dut (
        .clock(clock),
        .reset(reset),
        .operation(operation),
        .data_a(data_a),
        .data_b(data_b),
        .input_rdy(input_rdy),
        .input_ack(input_ack),
        .output_rdy(output_rdy),
        .output_ack(output_ack),
        .result(result),
        .flags(flags)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic [3:0] fl,
                          input int lat, input int hold);
        exp_t e;
        int n;
        sb_q.push_back('{res, fl, lat});
        @(negedge clock);
        operation = op;
        data_a = a;
        data_b = b;
        input_rdy = 1'b1;
        n = 0;
        do begin
            @(posedge clock);
            #1 n++;
        end while (!input_ack && n < 10);
        input_rdy = 1'b0;
        check({tag, "/ack"}, 32'(input_ack), 32'd1);
        n = 0;
        do begin
            @(posedge clock);
            #1 n++;
            if (n == 1) check({tag, "/ack_pulse"}, 32'(input_ack), 32'd0);
        end while (!output_rdy && n < 100);
        e = sb_q.pop_front();
        check({tag, "/lat"}, 32'(n), 32'(e.lat));
        check({tag, "/res"}, result, e.res);
        check({tag, "/flags"}, 32'(flags), 32'(e.fl));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1 check({tag, "/hold_rdy"}, 32'(output_rdy), 32'd1);
            check({tag, "/hold_res"}, result, e.res);
        end
        @(negedge clock);
        output_ack = 1'b1;
        @(posedge clock);
        #1 check({tag, "/drop"}, 32'(output_rdy), 32'd0);
        output_ack = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #1 check("rst/ack", 32'(input_ack), 32'd0);
        check("rst/rdy", 32'(output_rdy), 32'd0);
        check("rst/res", result, 32'd0);
        check("rst/flags", 32'(flags), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op("add_small", ADD, 32'h3F800000, 32'h3C23D70A, 32'h3F8147AE, 4'b0001, 4, 0);
        run_op("sub_equal", SUB, 32'h3FC00000, 32'h3FC00000, 32'h00000000, 4'b0000, 4, 0);
        run_op("add_neg", ADD, 32'hBF800000, 32'hC1433333, 32'hC1533333, 4'b0000, 4, 0);
        run_op("add_carry", ADD, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000, 4, 0);
        run_op("sub_half", SUB, 32'h3F800000, 32'h3F000000, 32'h3F000000, 4'b0000, 4, 0);
        run_op("rne_tie", ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001, 4, 0);
        run_op("rne_up", ADD, 32'h3F800000, 32'h33C00000, 32'h3F800001, 4'b0001, 4, 0);
        run_op("neg_zeros", ADD, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000, 4, 0);
        run_op("add_ovf", ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101, 4, 0);
        run_op("mul_2x2", MUL, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 27, 10);
        run_op("mul_neg", MUL, 32'hC0000000, 32'h40000000, 32'hC0800000, 4'b0000, 27, 0);
        run_op("mul_carry", MUL, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 27, 0);
        run_op("mul_zero", MUL, 32'h00000000, 32'hC0000000, 32'h80000000, 4'b0000, 27, 0);
        run_op("mul_ovf", MUL, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 27, 0);
        run_op("mul_unf", MUL, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 27, 0);
        run_op("inf_minus_inf", ADD, 32'h7F800000, 32'hFF800000, 32'hFFFFFFFF, 4'b1000, 2, 0);
        run_op("nan_mul", MUL, 32'h7FC00000, 32'h3F800000, 32'hFFFFFFFF, 4'b1000, 2, 0);
        run_op("illegal", BAD, 32'h3F800000, 32'h3F800000, 32'hFFFFFFFF, 4'b1000, 2, 0);
        run_op("inf_plus_one", ADD, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000, 2, 0);
        run_op("zero_x_inf", MUL, 32'h00000000, 32'h7F800000, 32'hFFFFFFFF, 4'b1000, 2, 0);

        output_ack = 1'b1;
        run_op("stale_ack", ADD, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000, 4, 0);

        @(negedge clock);
        operation = MUL;
        data_a = 32'h40000000;
        data_b = 32'h40000000;
        input_rdy = 1'b1;
        @(posedge clock);
        #1 input_rdy = 1'b0;
        check("mid_rst/ack", 32'(input_ack), 32'd1);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 check("mid_rst/ack0", 32'(input_ack), 32'd0);
        check("mid_rst/rdy0", 32'(output_rdy), 32'd0);
        check("mid_rst/res0", result, 32'd0);
        check("mid_rst/flags0", 32'(flags), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        repeat (40) begin
            @(posedge clock);
            #1 if (output_rdy) n++;
        end
        check("mid_rst/no_rdy", 32'(n), 32'd0);

        run_op("after_rst", ADD, 32'h3F800000, 32'h3C23D70A, 32'h3F8147AE, 4'b0001, 4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
